stream_splitter: RTL and testbench

Splits one 64-bit input stream into two 32-bit output streams with one register stage. Each accepted input word is emitted on both output ports in the same cycle: the low half on port 1 and the high half on port 2. It sits between a 64-bit sample source and two independent 32-bit lane consumers, such as I/Q or even/odd sample paths. The output side has no backpressure, so ready_in is high whenever the block is out of reset.

---
 rtl/stream_splitter.sv | 59 +++++
 tb/tb_stream_splitter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/stream_splitter.sv
// rtl/stream_splitter.sv - splits one wide input stream into low/high half-width output streams
// One register stage; no output backpressure, so ready_in is simply "out of reset".
module stream_splitter #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   slave_data,
  input  logic                    valid_in,
  output logic                    ready_in,
  output logic [DATA_WIDTH/2-1:0] data_port1,
  output logic                    valid1,
  output logic [DATA_WIDTH/2-1:0] data_port2,
  output logic                    valid2
);

  localparam int HALF = DATA_WIDTH / 2;

  logic            ready_q;
  logic            valid_q, valid_d;
  logic [HALF-1:0] lo_q, lo_d;
  logic [HALF-1:0] hi_q, hi_d;
  logic            accept;

  assign accept = valid_in & ready_q;

  // Data registers only load on accept, so unknowns on idle cycles never reach the outputs.
  always_comb begin
    valid_d = accept;
    lo_d    = lo_q;
    hi_d    = hi_q;
    if (accept) begin
      lo_d = slave_data[HALF-1:0];
      hi_d = slave_data[DATA_WIDTH-1:HALF];
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      ready_q <= 1'b1;
      valid_q <= valid_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign ready_in   = ready_q;
  assign data_port1 = lo_q;
  assign data_port2 = hi_q;
  assign valid1     = valid_q;
  assign valid2     = valid_q;

endmodule

// File: tb/tb_stream_splitter.sv
// tb/tb_stream_splitter.sv - directed self-checking bench for stream_splitter
module tb_stream_splitter;

  logic        clk;
  logic        rst_n;
  logic [63:0] slave_data;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] data_port1;
  logic        valid1;
  logic [31:0] data_port2;
  logic        valid2;

  int n_checks = 0;
  int n_fail   = 0;

  stream_splitter #(.DATA_WIDTH(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .slave_data (slave_data),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .data_port1 (data_port1),
    .valid1     (valid1),
    .data_port2 (data_port2),
    .valid2     (valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_ready"}, {63'd0, ready_in}, 64'd0);
    check_eq({tag, "_valid"}, {62'd0, valid1, valid2}, 64'd0);
    check_eq({tag, "_data"}, {data_port2, data_port1}, 64'd0);
  endtask

  logic [63:0] gap_words [5];
  logic        gap_pat   [5];
  logic [63:0] exp_data;
  logic [63:0] w;

  initial begin
    rst_n      = 1'b1;
    valid_in   = 1'b1;
    slave_data = 64'hFFFF_FFFF_FFFF_FFFF;

    // reset held with active input
    repeat (5) begin
      @(negedge clk);
      check_idle_zero("reset");
    end

    // word presented on the releasing edge must be dropped
    rst_n      = 1'b0;
    slave_data = 64'hDEAD_BEEF_CAFE_F00D;
    valid_in   = 1'b1;
    @(negedge clk);
    check_eq("preready_ready", {63'd0, ready_in}, 64'd1);
    check_eq("preready_valid", {62'd0, valid1, valid2}, 64'd0);
    check_eq("preready_data", {data_port2, data_port1}, 64'd0);
    valid_in   = 1'b0;
    slave_data = 'x;
    @(negedge clk);
    check_eq("xidle_valid", {62'd0, valid1, valid2}, 64'd0);
    check_eq("xidle_data", {data_port2, data_port1}, 64'd0);

    // single word
    slave_data = 64'h1234_5678_9ABC_DEF0;
    valid_in   = 1'b1;
    @(negedge clk);
    check_eq("single_p1", {32'd0, data_port1}, 64'h0000_0000_9ABC_DEF0);
    check_eq("single_p2", {32'd0, data_port2}, 64'h0000_0000_1234_5678);
    check_eq("single_valid", {62'd0, valid1, valid2}, 64'd3);
    valid_in   = 1'b0;
    slave_data = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    check_eq("single_hold_valid", {62'd0, valid1, valid2}, 64'd0);
    check_eq("single_hold_data", {data_port2, data_port1}, 64'h1234_5678_9ABC_DEF0);

    // 1000 back-to-back words
    valid_in = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      slave_data = {32'(i + 1000), 32'(i)};
      @(negedge clk);
      check_eq("stream_data", {data_port2, data_port1}, {32'(i + 1000), 32'(i)});
      check_eq("stream_valid", {62'd0, valid1, valid2}, 64'd3);
    end
    valid_in = 1'b0;
    @(negedge clk);
    check_eq("stream_end_valid", {62'd0, valid1, valid2}, 64'd0);

    // gapped input 1,0,1,1,0; idle cycles carry different data that must not load
    gap_words[0] = 64'h0101_0101_A0A0_A0A0; gap_pat[0] = 1'b1;
    gap_words[1] = 64'h0202_0202_B1B1_B1B1; gap_pat[1] = 1'b0;
    gap_words[2] = 64'h0303_0303_C2C2_C2C2; gap_pat[2] = 1'b1;
    gap_words[3] = 64'h0404_0404_D3D3_D3D3; gap_pat[3] = 1'b1;
    gap_words[4] = 64'h0505_0505_E4E4_E4E4; gap_pat[4] = 1'b0;
    exp_data = {999 + 1000, 32'd999};
    for (int k = 0; k < 5; k++) begin
      valid_in   = gap_pat[k];
      slave_data = gap_words[k];
      @(negedge clk);
      if (gap_pat[k]) exp_data = gap_words[k];
      check_eq("gap_valid", {62'd0, valid1, valid2}, {62'd0, gap_pat[k], gap_pat[k]});
      check_eq("gap_data", {data_port2, data_port1}, exp_data);
    end

    // mid-stream asynchronous reset
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = {32'(16'hBEEF + i), 32'(16'h1000 + i)};
      slave_data = w;
      @(negedge clk);
      check_eq("pre_rst_data", {data_port2, data_port1}, w);
    end
    slave_data = 64'h7777_7777_8888_8888;
    #2 rst_n = 1'b1;
    #1;
    check_idle_zero("async_rst");
    @(negedge clk);
    check_idle_zero("held_rst");

    rst_n      = 1'b0;
    slave_data = 64'h9999_9999_6666_6666;
    @(negedge clk);
    check_eq("rel_ready", {63'd0, ready_in}, 64'd1);
    check_eq("rel_valid", {62'd0, valid1, valid2}, 64'd0);
    check_eq("rel_data", {data_port2, data_port1}, 64'd0);
    slave_data = 64'h0BAD_F00D_1357_2468;
    @(negedge clk);
    check_eq("resume_data", {data_port2, data_port1}, 64'h0BAD_F00D_1357_2468);
    check_eq("resume_valid", {62'd0, valid1, valid2}, 64'd3);
    valid_in = 1'b0;
    @(negedge clk);
    check_eq("resume_idle_valid", {62'd0, valid1, valid2}, 64'd0);
    check_eq("resume_ready", {63'd0, ready_in}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
